uart_freq_rx: RTL

Receive side of the frequency meter's serial link. Takes the `uart_tx` line driven by `top_freq_meter` (8N1, LSB first) and decodes it into bytes. Reassembles the meter's 6-byte measurement frame into a 32-bit frequency value in Hz. Used as the loopback checker in system benches and as the front end of the host-side capture FPGA.

---
 rtl/uart_freq_rx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_freq_rx.sv
// uart_freq_rx: 8N1 UART receiver that reassembles the meter's 6-byte frame (AA, F[31:0], XOR) into freq_hz.
module uart_freq_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_ferr,
  output logic [31:0] freq_hz,
  output logic        freq_valid,
  output logic        frame_err
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int TMO  = TIMEOUT_BITS * CPB;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TW   = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} bit_t;
  typedef enum logic [1:0] {HDR, PAY, CHK} par_t;

  bit_t        bs;
  par_t        ps;
  logic [1:0]  sync;
  logic        rx;
  logic [CW-1:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic [1:0]  bidx;
  logic [31:0] acc;
  logic [7:0]  x;
  logic [TW-1:0] tcnt;

  assign rx = sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync     <= 2'b11;
      bs       <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync     <= {sync[0], uart_rx};
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (bs)
        IDLE: if (!rx) begin
          cnt <= '0;
          bs  <= START;
        end
        START: if (cnt == CW'(HALF - 1)) begin
          cnt <= '0;
          idx <= '0;
          bs  <= rx ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == CW'(CPB - 1)) begin
          cnt <= '0;
          sh  <= {rx, sh[7:1]};
          idx <= idx + 1'b1;
          if (idx == 3'd7) bs <= STOP;
        end else cnt <= cnt + 1'b1;
        // Stop sampled mid-bit leaves half a bit to catch a back-to-back start edge
        STOP: if (cnt == CW'(CPB - 1)) begin
          cnt <= '0;
          if (rx) begin
            rx_data  <= sh;
            rx_valid <= 1'b1;
            bs       <= IDLE;
          end else begin
            rx_ferr <= 1'b1;
            bs      <= WAIT_HIGH;
          end
        end else cnt <= cnt + 1'b1;
        WAIT_HIGH: if (rx) bs <= IDLE;
        default: bs <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps         <= HDR;
      bidx       <= '0;
      acc        <= '0;
      x          <= '0;
      tcnt       <= '0;
      freq_hz    <= '0;
      freq_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      frame_err  <= 1'b0;
      tcnt       <= (ps == HDR || rx_valid) ? '0 : tcnt + 1'b1;
      // A byte arriving in the expiry cycle takes precedence over the timeout
      if (rx_valid) begin
        case (ps)
          HDR: if (rx_data == 8'hAA) begin
            ps   <= PAY;
            bidx <= '0;
            acc  <= '0;
            x    <= '0;
          end
          PAY: begin
            acc  <= {acc[23:0], rx_data};
            x    <= x ^ rx_data;
            bidx <= bidx + 1'b1;
            if (bidx == 2'd3) ps <= CHK;
          end
          CHK: begin
            if (rx_data == x) begin
              freq_hz    <= acc;
              freq_valid <= 1'b1;
            end else frame_err <= 1'b1;
            ps <= HDR;
          end
          default: ps <= HDR;
        endcase
      end else if (ps != HDR && (rx_ferr || tcnt == TW'(TMO))) begin
        frame_err <= 1'b1;
        acc       <= '0;
        x         <= '0;
        ps        <= HDR;
      end
    end
  end
endmodule
